uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter NUM_DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter BP_WIDTH, default 14, width of the bit_period input.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 tx_start  input  1  request to send one frame; sampled on rising clk.
REQ-006 tx_data  input  NUM_DATA_BITS  frame payload; sampled with tx_start.
REQ-007 bit_period  input  BP_WIDTH  clk cycles per serial bit; sampled with tx_start.
REQ-008 serial_out  output  1  serial line; idle/inactive value 1.
REQ-009 busy  output  1  high while a frame is being shifted out.
REQ-010 tx_done  output  1  one-cycle pulse after each completed frame.

Function
REQ-011 The frame SHALL be: 1 start bit (0), NUM_DATA_BITS data bits LSB first, 1 stop bit (1); each bit held exactly bit_period cycles.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-013 IDLE -> START SHALL occur on a rising edge where tx_start=1; tx_data and bit_period are latched on that edge.
REQ-014 serial_out SHALL go low in the first cycle after the accepting edge (one-cycle latency).
REQ-015 START -> DATA, DATA -> STOP, and STOP -> IDLE SHALL occur when the bit-period counter reaches bit_period, with the counter cleared on each transition; DATA advances the bit index each bit period and exits after index NUM_DATA_BITS-1.
REQ-016 A latched bit_period of 0 SHALL be treated as 1.
REQ-017 A full frame SHALL occupy exactly (NUM_DATA_BITS+2)*bit_period cycles.
REQ-018 busy SHALL be 1 in every START, DATA, and STOP cycle, and 0 in IDLE.
REQ-019 tx_done SHALL be 1 for exactly the first IDLE cycle after STOP completes, and 0 otherwise.
REQ-020 tx_start SHALL be ignored while busy=1.
REQ-021 Changes to tx_data or bit_period after acceptance SHALL NOT affect the frame in progress.
REQ-022 tx_start asserted in the tx_done cycle SHALL be accepted, giving exactly one idle-high cycle between back-to-back frames.
REQ-023 serial_out SHALL be driven directly from a flip-flop so that it is glitch-free.

Reset
REQ-024 While n_rst=0, regardless of clk: serial_out=1, busy=0, tx_done=0, state=IDLE, counters=0, latched data=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no tx_done pulse.
REQ-026 After reset release, the block SHALL accept tx_start on the first rising edge.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state enum type (IDLE, START, DATA, STOP), the default NUM_DATA_BITS and BP_WIDTH, and the constants START_BIT=0, STOP_BIT=1, and IDLE_LINE=1.
REQ-028 The bit-period timer SHALL be a flex_counter sub-module instance (BP_WIDTH wide, clear input, enable, rollover flag); the bit index may use a second flex_counter instance.
REQ-029 The data SHALL be held in a right-shifting register that emits its LSB to the serial_out flop.

Verification
REQ-030 Reset: n_rst=0 with clk running, then released at a falling edge -> serial_out=1, busy=0, tx_done=0 throughout, including at the cycle after release.
REQ-031 Normal frame: tx_data=8'hA5, bit_period=10, tx_start pulsed one cycle -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; busy high for 100 cycles; tx_done pulses in cycle 101 after acceptance.
REQ-032 Busy rejection: tx_start with tx_data=8'h00 pulsed during the 8'hA5 frame -> frame bits unchanged, no second frame.
REQ-033 Back-to-back: tx_start with tx_data=8'h3C asserted in the tx_done cycle -> one idle-high cycle, then start bit; data 0,0,1,1,1,1,0,0; stop 1.
REQ-034 Mid-frame reset: n_rst=0 during data bit 3 (line low) -> serial_out=1 and busy=0 in the same time step, no tx_done pulse; a new frame after release is correct.
REQ-035 Minimum period: bit_period=0, tx_data=8'hFF -> frame 0,1,1,1,1,1,1,1,1,1, each bit 1 cycle, total 10 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART transmitter slice: FSM state
//                type, default frame/timer widths and serial line levels.
//  Contents    : uart_state_t  - transmitter FSM state encoding
//                NUM_DATA_BITS_DEFAULT, BP_WIDTH_DEFAULT - parameter defaults
//                START_BIT, STOP_BIT, IDLE_LINE - serial line levels
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int NUM_DATA_BITS_DEFAULT = 8;
    localparam int BP_WIDTH_DEFAULT      = 14;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter
//  Description : Up-counter with programmable rollover value. The count runs
//                1..rollover_val and wraps back to 1; clear forces it to 0 and
//                takes priority over count_enable.
//  Ports       : clk           - system clock
//                n_rst         - asynchronous active-low reset
//                clear         - synchronous clear to 0
//                count_enable  - advance the count this cycle
//                rollover_val  - terminal count value
//                rollover_flag - high while the count equals rollover_val
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] c_one = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    w_at_terminal;

    assign w_at_terminal = (r_count == rollover_val);
    assign rollover_flag = w_at_terminal;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            // Wrapping to 1 (not 0) makes the terminal edge also the first
            // counted cycle of the next period, so periods stay exact.
            r_count <= w_at_terminal ? c_one : r_count + c_one;
        end
    end

endmodule : flex_counter
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter
//  Description : Serial UART transmitter. Sends one start bit, NUM_DATA_BITS
//                data bits LSB first and one stop bit, each held for the
//                bit_period latched when the frame was accepted.
//  Ports       : clk        - system clock (rising edge)
//                n_rst      - asynchronous active-low reset
//                tx_start   - request a frame (ignored while busy)
//                tx_data    - frame payload, latched with tx_start
//                bit_period - clk cycles per bit, latched with tx_start
//                serial_out - serial line, idles high, registered output
//                busy       - frame in progress
//                tx_done    - one-cycle pulse after each completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int NUM_DATA_BITS = NUM_DATA_BITS_DEFAULT,
    parameter int BP_WIDTH      = BP_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    input  logic [BP_WIDTH-1:0]      bit_period,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     tx_done
);

    localparam int c_idx_w = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_DATA_BITS - 1);

    uart_state_t              r_state;
    logic                     r_serial;
    logic                     r_tx_done;
    logic [NUM_DATA_BITS-1:0] r_shift;
    logic [BP_WIDTH-1:0]      r_period;

    logic                     w_accept;
    logic                     w_bit_roll;
    logic                     w_idx_last;
    logic                     w_bit_clear;
    logic                     w_idx_clear;
    logic                     w_idx_enable;
    logic [BP_WIDTH-1:0]      w_period_fixed;

    assign w_accept       = (r_state == IDLE) && tx_start;
    // A zero period would never let the timer terminate; run it as one cycle.
    assign w_period_fixed = (bit_period == '0) ? BP_WIDTH'(1) : bit_period;

    // Timer sits at 0 in IDLE so the accepting edge always starts the first
    // bit at count 1, including a back-to-back accept in the tx_done cycle.
    assign w_bit_clear  = ((r_state == IDLE) && !tx_start) ||
                          ((r_state == STOP) && w_bit_roll);
    assign w_idx_clear  = (r_state != DATA);
    assign w_idx_enable = (r_state == DATA) && w_bit_roll;

    flex_counter #(
        .NUM_CNT_BITS (BP_WIDTH)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_bit_clear),
        .count_enable  (1'b1),
        .rollover_val  (r_period),
        .rollover_flag (w_bit_roll)
    );

    flex_counter #(
        .NUM_CNT_BITS (c_idx_w)
    ) u_bit_index (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (w_idx_clear),
        .count_enable  (w_idx_enable),
        .rollover_val  (c_last_idx),
        .rollover_flag (w_idx_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_serial  <= IDLE_LINE;
            r_tx_done <= 1'b0;
            r_shift   <= '0;
            r_period  <= '0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_serial <= START_BIT;
                        r_shift  <= tx_data;
                        r_period <= w_period_fixed;
                    end
                end
                START: begin
                    if (w_bit_roll) begin
                        r_state  <= DATA;
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_bit_roll) begin
                        if (w_idx_last) begin
                            r_state  <= STOP;
                            r_serial <= STOP_BIT;
                        end else begin
                            r_serial <= r_shift[0];
                            r_shift  <= r_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_roll) begin
                        r_state   <= IDLE;
                        r_serial  <= IDLE_LINE;
                        r_tx_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_serial <= IDLE_LINE;
                end
            endcase
        end
    end

    assign serial_out = r_serial;
    assign busy       = (r_state != IDLE);
    assign tx_done    = r_tx_done;

endmodule : uart_transmitter
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_transmitter
//  Description : Self-checking bench for uart_transmitter. A frame-level model
//                expands each accepted request into the expected per-cycle
//                {serial_out, busy, tx_done} sequence; every cycle is compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int NB  = 8;
    localparam int BPW = 14;

    logic           tb_clk;
    logic           n_rst;
    logic           tx_start;
    logic [NB-1:0]  tx_data;
    logic [BPW-1:0] bit_period;
    logic           serial_out;
    logic           busy;
    logic           tx_done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [2:0] last_exp = 3'b100;

    uart_transmitter #(
        .NUM_DATA_BITS (NB),
        .BP_WIDTH      (BPW)
    ) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .bit_period (bit_period),
        .serial_out (serial_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Frame expansion: start bit, data LSB first, stop bit, each bit held for
    // max(bp,1) cycles with busy high, then one idle cycle carrying tx_done.
    task automatic push_frame(input logic [NB-1:0] d, input logic [BPW-1:0] bp);
        int  p;
        logic b;
        p = (bp == 0) ? 1 : int'(bp);
        for (int i = 0; i < NB + 2; i++) begin
            if (i == 0)       b = 1'b0;
            else if (i <= NB) b = d[i-1];
            else              b = 1'b1;
            for (int c = 0; c < p; c++) exp_q.push_back({b, 1'b1, 1'b0});
        end
        exp_q.push_back(3'b101);
    endtask

    // Raise a request before the next rising edge; the model accepts it only
    // if the transmitter was idle in the current cycle.
    task automatic start(input logic [NB-1:0] d, input logic [BPW-1:0] bp);
        tx_start   = 1'b1;
        tx_data    = d;
        bit_period = bp;
        if (last_exp[1] == 1'b0) push_frame(d, bp);
    endtask

    // Advance one cycle, compare outputs, then scramble the payload inputs so
    // any frame in progress must be running from its latched copies.
    task automatic step(input string tag);
        logic [2:0] e;
        @(negedge tb_clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
        check(tag, {29'd0, serial_out, busy, tx_done}, {29'd0, e});
        last_exp   = e;
        tx_start   = 1'b0;
        tx_data    = NB'($urandom);
        bit_period = BPW'($urandom);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) step(tag);
    endtask

    initial begin
        n_rst      = 1'b0;
        tx_start   = 1'b0;
        tx_data    = '0;
        bit_period = '0;

        // Reset held with clock running, released on a falling edge.
        repeat (3) begin
            @(negedge tb_clk);
            check("reset_hold", {29'd0, serial_out, busy, tx_done}, 32'h4);
        end
        n_rst = 1'b1;
        step("after_release");

        // Normal frame 0xA5 with period 10, plus a rejected request mid-frame.
        start(8'hA5, 14'd10);
        repeat (35) step("frame_a5");
        start(8'h00, 14'd3);
        drain("frame_a5_busy_reject");
        check("a5_done_seen", {31'd0, last_exp[0]}, 32'd1);

        // Back-to-back: request in the tx_done cycle.
        start(8'h3C, 14'd4);
        drain("frame_3c_b2b");
        repeat (3) step("idle_after_3c");

        // Minimum period: zero behaves as one cycle per bit.
        start(8'hFF, 14'd0);
        drain("frame_ff_bp0");
        step("idle_after_ff");

        // Mid-frame reset during data bit 3 (line low for 0xA5).
        start(8'hA5, 14'd10);
        repeat (42) step("frame_pre_reset");
        check("line_low_bit3", {31'd0, serial_out}, 32'd0);
        #2 n_rst = 1'b0;
        #1 check("reset_async", {29'd0, serial_out, busy, tx_done}, 32'h4);
        exp_q.delete();
        last_exp = 3'b100;
        step("reset_mid_hold");
        n_rst = 1'b1;
        // Request on the very first edge after release.
        start(8'h5A, 14'd2);
        drain("frame_after_reset");

        // Randomized frames with random gaps, periods and rejected requests.
        for (int f = 0; f < 8; f++) begin
            start(NB'($urandom), BPW'($urandom_range(0, 5)));
            repeat ($urandom_range(1, 8)) step("rand_frame");
            start(NB'($urandom), BPW'($urandom_range(0, 5)));
            drain("rand_frame");
            repeat ($urandom_range(0, 2)) step("rand_gap");
        end
        repeat (4) step("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_transmitter
`default_nettype wire
